bp_update_scheduler: RTL and testbench
======================================

Name: bp_update_scheduler

Overview:
- Sits between the execute stage and a predictor's history/pattern tables, where those tables have only one write port.
- Accepts up to two resolved branches per cycle (slot 1, slot 2) and queues them in a small FIFO. It then drains one table update per cycle, in program order.
- Owns table initialisation: after reset or an explicit flush it sweeps every table index once, issuing clear writes, before normal updates start.

Parameters:
- IDX_W, 10, table index width; index = Pc[IDX_W+1:2].
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- init_req  in  1  flush request: discard queued updates and re-clear tables
- branch1E  in  1  slot-1 instruction in E is a branch
- branch2E  in  1  slot-2 instruction in E is a branch
- Pc1E  in  32  slot-1 PC
- Pc2E  in  32  slot-2 PC
- actual_take1E  in  1  slot-1 resolved direction
- actual_take2E  in  1  slot-2 resolved direction
- pred_take1E  in  1  slot-1 predicted direction
- pred_take2E  in  1  slot-2 predicted direction
- in_ready  out  1  scheduler accepts this cycle's E-stage branches
- tbl_we  out  1  table write strobe
- tbl_clear  out  1  write is an initialisation clear (write zeros)
- tbl_index  out  IDX_W  table index
- tbl_take  out  1  resolved direction for update
- tbl_mispred  out  1  update came from a mispredicted branch
- init_busy  out  1  initialisation sweep in progress

Behaviour:
- States: INIT, RUN. Reset enters INIT with sweep counter 0, FIFO empty.
- Reset values: in_ready=0, init_busy=1, tbl_we=0, tbl_clear=0, tbl_index=0, tbl_take=0, tbl_mispred=0.
- All tbl_* outputs are registered.

INIT state:
- Each cycle issue tbl_we=1, tbl_clear=1, tbl_index=counter; counter increments.
- After index 2^IDX_W-1 is issued, go to RUN the next cycle. The sweep takes exactly 2^IDX_W cycles.
- init_busy=1 and in_ready=0 throughout INIT.

RUN state:
- in_ready = (free entries >= 2). It uses the registered count only, so there is no combinational path from the dequeue side.
- When in_ready=1, enqueue each slot with branchXE=1. If both are valid, slot 1 goes first.
- Each entry is {index, take, mispred}, with mispred = pred_take ^ actual_take.
- When in_ready=0, inputs are ignored; the pipeline must hold E and re-present the branches.
- Dequeue: if the FIFO is non-empty at cycle t, the head appears on tbl_* with tbl_we=1 and tbl_clear=0 at t+1. One pop per cycle.
- Minimum latency from enqueue to tbl_we is 1 cycle. An entry enqueued into an empty FIFO appears the next cycle.
- Enqueue and dequeue in the same cycle are legal: count += enq_n − deq_n.
- Read and write pointers wrap modulo DEPTH.
- When empty, tbl_we=0 and the other tbl_* hold their last values.

init_req and reset priority:
- init_req in RUN (highest priority after rst): FIFO is cleared, any same-cycle enqueue is dropped, the counter resets to 0, and the state goes to INIT next cycle.
- init_req while already in INIT restarts the sweep at 0.
- rst mid-sweep or with entries queued: immediate return to the reset state, with no writes issued that cycle.

Optional Feature:
- Macro: BP_UPD_STAT_EN.
- Defined: adds output stat_upd_cnt (32b), counting RUN-state update writes issued, and output stat_mispred_cnt (32b), counting issued writes with tbl_mispred=1.
- Both counters wrap at 2^32 and are cleared by rst only, not by init_req.
- Not defined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset with IDX_W=4 → 16 consecutive cycles with tbl_we=1, tbl_clear=1, index 0..15 in order; then init_busy=0 and in_ready=1.
- RUN, one cycle with branch1E=branch2E=1, Pc1E=0x1004, Pc2E=0x1008, actual 1/0, pred 1/1 → next two cycles write index 1 (take=1, mispred=0) then index 2 (take=0, mispred=1); then tbl_we=0.
- DEPTH=4, dual branches three cycles in a row, no drain stall → in_ready drops to 0 when count>2; no entry is lost or reordered; all 6 updates are issued in order.
- Only branch2E=1 at Pc2E=0x40 → a single write, index 0x10.
- 3 entries queued, init_req=1 → the queued entries are never written; a full 2^IDX_W clear sweep restarts at index 0.
- With BP_UPD_STAT_EN: 5 updates, 2 mispredicted → stat_upd_cnt=5, stat_mispred_cnt=2; a following init_req leaves both unchanged.

Source files
------------

// File: rtl/bp_update_scheduler_if.sv
// Execute-stage branch inputs and predictor-table write bus for bp_update_scheduler.
// The scheduler uses the slave modport; the execute/table side uses master.
interface bp_update_scheduler_if #(
    parameter int IDX_W = 10
);
    logic              init_req;
    logic              branch1E;
    logic              branch2E;
    logic [31:0]       Pc1E;
    logic [31:0]       Pc2E;
    logic              actual_take1E;
    logic              actual_take2E;
    logic              pred_take1E;
    logic              pred_take2E;
    logic              in_ready;
    logic              tbl_we;
    logic              tbl_clear;
    logic [IDX_W-1:0]  tbl_index;
    logic              tbl_take;
    logic              tbl_mispred;
    logic              init_busy;

    modport slave (
        input  init_req, branch1E, branch2E, Pc1E, Pc2E,
               actual_take1E, actual_take2E, pred_take1E, pred_take2E,
        output in_ready, tbl_we, tbl_clear, tbl_index, tbl_take, tbl_mispred, init_busy
    );

    modport master (
        output init_req, branch1E, branch2E, Pc1E, Pc2E,
               actual_take1E, actual_take2E, pred_take1E, pred_take2E,
        input  in_ready, tbl_we, tbl_clear, tbl_index, tbl_take, tbl_mispred, init_busy
    );
endinterface

// File: rtl/bp_update_scheduler.sv
// Serialises up to two resolved branches per cycle onto a single-port predictor table
// write bus, and clears the table after reset/flush. Optional counters: BP_UPD_STAT_EN.
module bp_update_scheduler #(
    parameter int IDX_W = 10,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    bp_update_scheduler_if.slave bus
`ifdef BP_UPD_STAT_EN
    ,
    output logic [31:0] stat_upd_cnt,
    output logic [31:0] stat_mispred_cnt
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] ONE = PW'(1);

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             take;
        logic             mis;
    } entry_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] sweep, sweep_nx;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count, count_nx, free;
    entry_t           mem [DEPTH];
    entry_t           e1, e2, first, head;
    logic             acc, enq1, enq2, deq;
    logic [1:0]       enq_n;

    logic             we_q, clear_q, take_q, mis_q;
    logic [IDX_W-1:0] index_q;

    logic unused_pc;
    assign unused_pc = ^{bus.Pc1E[31:IDX_W+2], bus.Pc1E[1:0], bus.Pc2E[31:IDX_W+2], bus.Pc2E[1:0]};

    assign e1 = '{idx: bus.Pc1E[IDX_W+1:2], take: bus.actual_take1E,
                  mis: bus.pred_take1E ^ bus.actual_take1E};
    assign e2 = '{idx: bus.Pc2E[IDX_W+1:2], take: bus.actual_take2E,
                  mis: bus.pred_take2E ^ bus.actual_take2E};

    // Ready looks only at the registered count, so it never depends on this cycle's pop.
    assign free         = CW'(DEPTH) - count;
    assign bus.in_ready = (state == RUN) && (free >= CW'(2));
    assign bus.init_busy = (state == INIT);

    assign acc   = bus.in_ready && !bus.init_req;
    assign enq1  = acc && bus.branch1E;
    assign enq2  = acc && bus.branch2E;
    assign enq_n = {1'b0, enq1} + {1'b0, enq2};
    assign first = enq1 ? e1 : e2;

    // An empty FIFO bypasses the incoming first entry straight to the write bus.
    assign head     = (count != '0) ? mem[rd_ptr] : first;
    assign deq      = (state == RUN) && !bus.init_req && ((count != '0) || (enq_n != 2'd0));
    assign count_nx = count + CW'(enq_n) - CW'(deq);

    always_comb begin
        state_nx = state;
        sweep_nx = sweep;
        if (bus.init_req) begin
            state_nx = INIT;
            sweep_nx = '0;
        end else if (state == INIT) begin
            sweep_nx = sweep + IDX_W'(1);
            if (sweep == '1) state_nx = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (acc && enq_n != 2'd0) mem[wr_ptr] <= first;
        if (enq1 && enq2)         mem[wr_ptr + ONE] <= e2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            sweep   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            we_q    <= 1'b0;
            clear_q <= 1'b0;
            index_q <= '0;
            take_q  <= 1'b0;
            mis_q   <= 1'b0;
`ifdef BP_UPD_STAT_EN
            stat_upd_cnt     <= '0;
            stat_mispred_cnt <= '0;
`endif
        end else begin
            state <= state_nx;
            sweep <= sweep_nx;
            if (bus.init_req) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                we_q    <= 1'b0;
                clear_q <= 1'b0;
            end else if (state == INIT) begin
                we_q    <= 1'b1;
                clear_q <= 1'b1;
                index_q <= sweep;
                take_q  <= 1'b0;
                mis_q   <= 1'b0;
            end else begin
                wr_ptr  <= wr_ptr + PW'(enq_n);
                rd_ptr  <= rd_ptr + PW'(deq);
                count   <= count_nx;
                we_q    <= deq;
                clear_q <= 1'b0;
                if (deq) begin
                    index_q <= head.idx;
                    take_q  <= head.take;
                    mis_q   <= head.mis;
                end
            end
`ifdef BP_UPD_STAT_EN
            if (deq) begin
                stat_upd_cnt <= stat_upd_cnt + 32'd1;
                if (head.mis) stat_mispred_cnt <= stat_mispred_cnt + 32'd1;
            end
`endif
        end
    end

    assign bus.tbl_we      = we_q;
    assign bus.tbl_clear   = clear_q;
    assign bus.tbl_index   = index_q;
    assign bus.tbl_take    = take_q;
    assign bus.tbl_mispred = mis_q;
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Randomised and directed bench for bp_update_scheduler against a queue-based model.
module tb_bp_update_scheduler;
    localparam int IDX_W = 4;
    localparam int DEPTH = 4;
    localparam int N     = 1 << IDX_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_update_scheduler_if #(.IDX_W(IDX_W)) bus();
`ifdef BP_UPD_STAT_EN
    logic [31:0] stat_upd_cnt, stat_mispred_cnt;
`endif

    bp_update_scheduler #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef BP_UPD_STAT_EN
        ,
        .stat_upd_cnt(stat_upd_cnt),
        .stat_mispred_cnt(stat_mispred_cnt)
`endif
    );

    typedef struct {
        int idx;
        bit take;
        bit mis;
    } upd_t;

    upd_t   q[$];
    bit     m_run;
    int     m_sweep;
    bit     m_we, m_clear, m_take, m_mis;
    int     m_idx;
    longint m_upd, m_mc;
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_run = 0; m_sweep = 0;
        m_we = 0; m_clear = 0; m_idx = 0; m_take = 0; m_mis = 0;
        m_upd = 0; m_mc = 0;
    endfunction

    // One clock: drive at negedge, check ready, advance model at posedge, check outputs at negedge.
    task automatic cycle(input bit r, input bit ir, input bit b1, input bit b2,
                         input logic [31:0] p1, input logic [31:0] p2,
                         input bit a1, input bit a2, input bit pr1, input bit pr2,
                         output bit acc);
        bit exp_ready;
        upd_t e;
        rst = r;
        bus.init_req = ir;
        bus.branch1E = b1;       bus.branch2E = b2;
        bus.Pc1E = p1;           bus.Pc2E = p2;
        bus.actual_take1E = a1;  bus.actual_take2E = a2;
        bus.pred_take1E = pr1;   bus.pred_take2E = pr2;
        exp_ready = m_run && ((DEPTH - q.size()) >= 2);
        #1;
        chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        chk("init_busy", 64'(bus.init_busy), 64'(!m_run));
        acc = exp_ready && !ir && !r;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (ir) begin
            q.delete();
            m_run = 0; m_sweep = 0; m_we = 0; m_clear = 0;
        end else if (!m_run) begin
            m_we = 1; m_clear = 1; m_idx = m_sweep; m_take = 0; m_mis = 0;
            m_sweep++;
            if (m_sweep == N) begin m_run = 1; m_sweep = 0; end
        end else begin
            if (acc && b1) q.push_back('{idx: int'((p1 >> 2) % N), take: a1, mis: a1 != pr1});
            if (acc && b2) q.push_back('{idx: int'((p2 >> 2) % N), take: a2, mis: a2 != pr2});
            if (q.size() > 0) begin
                e = q.pop_front();
                m_we = 1; m_clear = 0; m_idx = e.idx; m_take = e.take; m_mis = e.mis;
                m_upd++;
                if (e.mis) m_mc++;
            end else begin
                m_we = 0; m_clear = 0;
            end
        end
        @(negedge clk);
        chk("tbl_we", 64'(bus.tbl_we), 64'(m_we));
        chk("tbl_clear", 64'(bus.tbl_clear), 64'(m_clear));
        chk("tbl_index", 64'(bus.tbl_index), 64'(m_idx));
        chk("tbl_take", 64'(bus.tbl_take), 64'(m_take));
        chk("tbl_mispred", 64'(bus.tbl_mispred), 64'(m_mis));
`ifdef BP_UPD_STAT_EN
        chk("stat_upd", 64'(stat_upd_cnt), 64'(m_upd[31:0]));
        chk("stat_mis", 64'(stat_mispred_cnt), 64'(m_mc[31:0]));
`endif
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    // Re-present a pair of branches until the scheduler takes them.
    task automatic send(input bit b1, input bit b2, input logic [31:0] p1, input logic [31:0] p2,
                        input bit a1, input bit a2, input bit pr1, input bit pr2);
        bit acc = 0;
        int tries = 0;
        while (!acc && tries < 40) begin
            cycle(0, 0, b1, b2, p1, p2, a1, a2, pr1, pr2, acc);
            tries++;
        end
        if (!acc) chk("send_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        bit acc;
        bus.init_req = 0; bus.branch1E = 0; bus.branch2E = 0;
        bus.Pc1E = 0; bus.Pc2E = 0;
        bus.actual_take1E = 0; bus.actual_take2E = 0;
        bus.pred_take1E = 0; bus.pred_take2E = 0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);

        // Reset state, then the full clear sweep
        cycle(1, 0, 1, 1, 32'h4, 32'h8, 1, 1, 0, 0, acc);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        idle(N + 2);

        // Dual branch: index 1 then index 2 (mispredicted)
        send(1, 1, 32'h1004, 32'h1008, 1, 0, 1, 1);
        idle(3);

        // Three dual cycles back to back fill the FIFO and stall ready
        send(1, 1, 32'h10, 32'h14, 1, 0, 0, 0);
        send(1, 1, 32'h18, 32'h1c, 0, 1, 1, 1);
        send(1, 1, 32'h20, 32'h24, 1, 1, 0, 1);
        send(1, 1, 32'h28, 32'h2c, 0, 0, 1, 0);
        idle(8);

        // Slot 2 only
        send(0, 1, 32'h0, 32'h40, 0, 1, 0, 1);
        idle(2);

        // Queue three entries then flush: none of them may be written
        send(1, 1, 32'h30, 32'h34, 1, 1, 1, 1);
        send(1, 1, 32'h38, 32'h3c, 1, 1, 1, 1);
        send(1, 1, 32'h20, 32'h24, 1, 1, 1, 1);
        cycle(0, 1, 1, 1, 32'h0, 32'h4, 1, 1, 0, 0, acc);
        idle(N + 3);

        // Flush in the middle of a sweep restarts it
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        idle(5);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        idle(N + 2);

`ifdef BP_UPD_STAT_EN
        begin
            cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
            idle(N + 1);
            send(1, 0, 32'h100, 0, 1, 0, 1, 0);
            send(1, 0, 32'h104, 0, 0, 0, 1, 0);
            send(0, 1, 0, 32'h108, 0, 1, 0, 1);
            send(1, 0, 32'h10c, 0, 1, 0, 0, 0);
            send(0, 1, 0, 32'h110, 0, 0, 0, 0);
            idle(3);
            chk("stat_upd_5", 64'(stat_upd_cnt), 64'(5));
            chk("stat_mis_2", 64'(stat_mispred_cnt), 64'(2));
            cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, acc);
            idle(3);
            chk("stat_upd_hold", 64'(stat_upd_cnt), 64'(5));
            chk("stat_mis_hold", 64'(stat_mispred_cnt), 64'(2));
            idle(N);
        end
`endif

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            bit r  = ($urandom_range(0, 299) == 0);
            bit ir = ($urandom_range(0, 99) == 0);
            cycle(r, ir, 1'($urandom), 1'($urandom), $urandom, $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), acc);
        end
        idle(N + 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
